mbisr_repair_remap: RTL and testbench
=====================================

Name: mbisr_repair_remap

Overview:
- Repair-side counterpart to the MBIST controller in the mbist/mbisr design.
- Receives failing-address reports from the BIST engine during a learn phase and allocates spare rows to them.
- After learning, remaps functional accesses: a faulty row address resolves to its spare-row index.
- Reports repair success or unrepairable status to the top-level wrapper.

Parameters:
- ADDR_W, 4, width of the memory row address.
- NUM_SPARES, 2, number of spare rows / CAM entries (1..8).
- IDX_W, 3, width of the spare index output; must satisfy 2**IDX_W >= NUM_SPARES.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- learn_start  in  1  single-cycle pulse; clears the CAM and enters LEARN.
- fail_valid  in  1  BIST fail report is valid.
- fail_addr  in  ADDR_W  failing row address.
- fail_ready  out  1  block accepts a fail report this cycle.
- learn_done  in  1  single-cycle pulse; BIST finished, close learning.
- acc_addr  in  ADDR_W  functional access row address.
- remap_hit  out  1  registered: the previous-cycle acc_addr matched a repaired row.
- remap_idx  out  IDX_W  registered: matching spare index; 0 when no hit.
- spares_used  out  IDX_W+1  number of allocated spares.
- repair_ok  out  1  sticky: DONE reached with no overflow.
- unrepairable  out  1  sticky: more distinct fails than spares.
- fail_cnt  out  8  total accepted fail reports (optional feature only).

Behaviour:
- Reset (asynchronous, rst_n low):
  - state = IDLE.
  - All CAM valid bits cleared.
  - spares_used, remap_hit, remap_idx, repair_ok, unrepairable, fail_cnt all = 0.
  - fail_ready = 0.
- States:
  - IDLE -> LEARN on learn_start.
  - LEARN -> DONE on learn_done.
  - DONE -> LEARN on learn_start.
  - learn_start in LEARN restarts learning: CAM cleared, flags cleared, state stays LEARN.
- Entering LEARN (from any state):
  - CAM valids, spares_used, repair_ok, unrepairable and fail_cnt cleared in the same edge.
- fail_ready:
  - Combinational, = (state == LEARN).
  - A report is accepted on an edge where fail_valid && fail_ready.
- Accepted report, evaluated against the CAM contents before the edge:
  - fail_addr already present in a valid entry: no allocation (duplicate).
  - Else if spares_used < NUM_SPARES: write entry[spares_used] = fail_addr, set its valid bit, increment spares_used.
  - Else: set unrepairable (sticky until the next learn_start or reset). spares_used saturates at NUM_SPARES.
- fail_valid outside LEARN: ignored, with no side effects.
- Simultaneous learn_done and an accepted fail on the same edge:
  - The fail is processed first, then state = DONE.
  - On entering DONE, repair_ok = ~unrepairable, using the value that includes this fail.
- Simultaneous learn_start and fail_valid in LEARN: the clear wins; the report is dropped.
- Remap lookup:
  - Active in DONE only; in IDLE and LEARN, remap_hit = 0 and remap_idx = 0.
  - Parallel compare of acc_addr against all valid entries.
  - Latency 1 cycle: remap_hit/remap_idx at edge N+1 reflect acc_addr sampled at edge N.
  - Multiple matches are impossible by construction; if one occurs, the lowest index wins.
- The remap stays active even if unrepairable = 1: allocated spares are still used, and the system decides how to act on the flag.
- Reset mid-LEARN or mid-DONE: everything returns to the reset values and all learned repairs are lost.

Optional Feature:
- Macro: MBISR_FAIL_COUNT_EN.
- Defined:
  - fail_cnt is an 8-bit counter incremented on every accepted report, including duplicates and overflow reports.
  - Saturates at 255.
  - Cleared on entering LEARN and on reset.
- Not defined: fail_cnt is tied to 0 and no counter flops are built.

Test Plan:
- Reset/idle: rst_n low mid-run -> all outputs 0 immediately; fail_valid=1 with fail_addr=4'h3 in IDLE -> fail_ready=0, spares_used stays 0.
- Basic repair: learn_start; fails 4'h5 then 4'hA; learn_done -> spares_used=2, repair_ok=1. acc_addr=4'hA -> next cycle remap_hit=1, remap_idx=1. acc_addr=4'h2 -> remap_hit=0.
- Duplicate: fails 4'h7, 4'h7, 4'h7 -> spares_used=1, unrepairable=0; fail_cnt=3 if MBISR_FAIL_COUNT_EN is defined.
- Overflow: fails 4'h1, 4'h2, 4'h3 with NUM_SPARES=2 -> unrepairable=1 after the third; learn_done -> repair_ok=0; acc_addr=4'h2 -> remap_hit=1, remap_idx=1.
- Same-edge: fail 4'hC presented together with learn_done -> entry 0 = 4'hC, state DONE, repair_ok=1, spares_used=1.
- Relearn: after DONE with 2 spares, learn_start -> spares_used=0, repair_ok=0, and the old address 4'h5 gives remap_hit=0 until relearned.

Source files
------------

// File: rtl/mbisr_repair_remap.sv
// Spare-row repair allocator and remap CAM for the MBIST/MBISR pair.
// Optional MBISR_FAIL_COUNT_EN builds an 8-bit saturating counter of accepted fail reports.
module mbisr_repair_remap #(
  parameter int ADDR_W     = 4,
  parameter int NUM_SPARES = 2,
  parameter int IDX_W      = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              learn_start,
  input  logic              fail_valid,
  input  logic [ADDR_W-1:0] fail_addr,
  output logic              fail_ready,
  input  logic              learn_done,
  input  logic [ADDR_W-1:0] acc_addr,
  output logic              remap_hit,
  output logic [IDX_W-1:0]  remap_idx,
  output logic [IDX_W:0]    spares_used,
  output logic              repair_ok,
  output logic              unrepairable,
  output logic [7:0]        fail_cnt
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LEARN = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [IDX_W:0] SPARES_MAX = (IDX_W+1)'(NUM_SPARES);

  logic [1:0]            state;
  logic [ADDR_W-1:0]     cam_addr [NUM_SPARES];
  logic [NUM_SPARES-1:0] cam_valid;
  logic [NUM_SPARES-1:0] alloc_onehot;
  logic                  accept, dup, full, alloc, overflow;
  logic                  hit_c;
  logic [IDX_W-1:0]      idx_c;

  assign fail_ready = (state == S_LEARN);
  // A restart on the same edge drops the report.
  assign accept     = fail_ready && fail_valid && !learn_start;
  assign full       = (spares_used >= SPARES_MAX);
  assign alloc      = accept && !dup && !full;
  assign overflow   = accept && !dup && full;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can leave it unassigned and infer a latch.
    dup          = 1'b0;
    hit_c        = 1'b0;
    idx_c        = '0;
    alloc_onehot = '0;
    // Descending scan so the lowest matching index is the one left standing.
    for (int i = NUM_SPARES - 1; i >= 0; i--) begin
      if (cam_valid[i] && cam_addr[i] == fail_addr) dup = 1'b1;
      if (cam_valid[i] && cam_addr[i] == acc_addr) begin
        hit_c = 1'b1;
        idx_c = IDX_W'(i);
      end
      if (alloc && spares_used == (IDX_W+1)'(i)) alloc_onehot[i] = 1'b1;
    end
  end

  // NOTE: the CAM address storage has no reset; an entry is meaningless until its valid bit is set.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_SPARES; i++) begin
      if (alloc_onehot[i]) cam_addr[i] <= fail_addr;
    end
  end

  // NOTE: all state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      cam_valid    <= '0;
      spares_used  <= '0;
      repair_ok    <= 1'b0;
      unrepairable <= 1'b0;
    end else if (learn_start) begin
      state        <= S_LEARN;
      cam_valid    <= '0;
      spares_used  <= '0;
      repair_ok    <= 1'b0;
      unrepairable <= 1'b0;
    end else if (state == S_LEARN) begin
      cam_valid <= cam_valid | alloc_onehot;
      if (alloc)    spares_used  <= spares_used + (IDX_W+1)'(1);
      if (overflow) unrepairable <= 1'b1;
      // The report on this edge is folded into the verdict.
      if (learn_done) begin
        state     <= S_DONE;
        repair_ok <= ~(unrepairable | overflow);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      remap_hit <= 1'b0;
      remap_idx <= '0;
    end else if (state == S_DONE && !learn_start) begin
      remap_hit <= hit_c;
      remap_idx <= idx_c;
    end else begin
      remap_hit <= 1'b0;
      remap_idx <= '0;
    end
  end

`ifdef MBISR_FAIL_COUNT_EN
  logic [7:0] fail_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail_cnt_q <= '0;
    end else if (learn_start) begin
      fail_cnt_q <= '0;
    end else if (accept && fail_cnt_q != 8'hFF) begin
      fail_cnt_q <= fail_cnt_q + 8'd1;
    end
  end

  assign fail_cnt = fail_cnt_q;
`else
  assign fail_cnt = '0;
`endif

endmodule

// File: tb/tb_mbisr_repair_remap.sv
// Directed bench for mbisr_repair_remap: list-based reference model checked every cycle plus literal pins.
// Honours MBISR_FAIL_COUNT_EN when the bundle is built with it.
module tb_mbisr_repair_remap;

  localparam int ADDR_W     = 4;
  localparam int NUM_SPARES = 2;
  localparam int IDX_W      = 3;
  localparam int M_IDLE = 0, M_LEARN = 1, M_DONE = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              learn_start = 1'b0;
  logic              fail_valid = 1'b0;
  logic [ADDR_W-1:0] fail_addr = '0;
  logic              fail_ready;
  logic              learn_done = 1'b0;
  logic [ADDR_W-1:0] acc_addr = '0;
  logic              remap_hit;
  logic [IDX_W-1:0]  remap_idx;
  logic [IDX_W:0]    spares_used;
  logic              repair_ok;
  logic              unrepairable;
  logic [7:0]        fail_cnt;

  int n_pass  = 0;
  int n_total = 0;

  mbisr_repair_remap #(.ADDR_W(ADDR_W), .NUM_SPARES(NUM_SPARES), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst_n(rst_n), .learn_start(learn_start), .fail_valid(fail_valid),
    .fail_addr(fail_addr), .fail_ready(fail_ready), .learn_done(learn_done),
    .acc_addr(acc_addr), .remap_hit(remap_hit), .remap_idx(remap_idx),
    .spares_used(spares_used), .repair_ok(repair_ok), .unrepairable(unrepairable),
    .fail_cnt(fail_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask

  // Reference model: spare list in allocation order, flags, and the registered lookup result.
  int         m_state, m_used, m_cnt, m_idx;
  bit         m_unrep, m_ok, m_hit;
  logic [3:0] m_list [8];

  always @(posedge clk or negedge rst_n) begin : model
    int n_state, n_used, n_cnt, found;
    bit n_unrep, n_ok, seen;
    if (!rst_n) begin
      m_state <= M_IDLE; m_used <= 0; m_cnt <= 0; m_unrep <= 0; m_ok <= 0;
      m_hit <= 0; m_idx <= 0;
    end else begin
      n_state = m_state; n_used = m_used; n_cnt = m_cnt; n_unrep = m_unrep; n_ok = m_ok;
      found = -1;
      if (m_state == M_DONE && !learn_start)
        for (int i = 0; i < m_used; i++)
          if (found < 0 && m_list[i] == acc_addr) found = i;
      m_hit <= (found >= 0);
      m_idx <= (found >= 0) ? found : 0;
      if (learn_start) begin
        n_state = M_LEARN; n_used = 0; n_cnt = 0; n_unrep = 0; n_ok = 0;
      end else if (m_state == M_LEARN) begin
        if (fail_valid) begin
`ifdef MBISR_FAIL_COUNT_EN
          if (n_cnt < 255) n_cnt = n_cnt + 1;
`endif
          seen = 0;
          for (int i = 0; i < m_used; i++) if (m_list[i] == fail_addr) seen = 1;
          if (!seen) begin
            if (n_used < NUM_SPARES) begin
              m_list[n_used] <= fail_addr;
              n_used = n_used + 1;
            end else begin
              n_unrep = 1;
            end
          end
        end
        if (learn_done) begin
          n_state = M_DONE;
          n_ok = !n_unrep;
        end
      end
      m_state <= n_state; m_used <= n_used; m_cnt <= n_cnt; m_unrep <= n_unrep; m_ok <= n_ok;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("fail_ready",   int'(fail_ready),   int'(m_state == M_LEARN));
      check("spares_used",  int'(spares_used),  m_used);
      check("repair_ok",    int'(repair_ok),    int'(m_ok));
      check("unrepairable", int'(unrepairable), int'(m_unrep));
      check("remap_hit",    int'(remap_hit),    int'(m_hit));
      check("remap_idx",    int'(remap_idx),    m_idx);
      check("fail_cnt",     int'(fail_cnt),     m_cnt);
    end
  end

  task automatic cyc(input bit ls, input bit fv, input logic [3:0] fa, input bit ld, input logic [3:0] aa);
    learn_start = ls; fail_valid = fv; fail_addr = fa; learn_done = ld; acc_addr = aa;
    @(posedge clk);
    #1;
    learn_start = 1'b0; fail_valid = 1'b0; learn_done = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("rst spares_used", int'(spares_used), 0);
    check("rst remap_hit",   int'(remap_hit),   0);

    // Fail report in IDLE is ignored.
    cyc(0, 1, 4'h3, 0, 4'h0);
    check("idle fail_ready", int'(fail_ready),  0);
    check("idle spares",     int'(spares_used), 0);

    // Basic repair.
    cyc(1, 0, 4'h0, 0, 4'h0);
    check("learn fail_ready", int'(fail_ready), 1);
    cyc(0, 1, 4'h5, 0, 4'h0);
    cyc(0, 1, 4'hA, 0, 4'h0);
    cyc(0, 0, 4'h0, 1, 4'h0);
    check("basic spares", int'(spares_used), 2);
    check("basic ok",     int'(repair_ok),   1);
    cyc(0, 0, 4'h0, 0, 4'hA);
    check("basic hit A",  int'(remap_hit),   1);
    check("basic idx A",  int'(remap_idx),   1);
    cyc(0, 0, 4'h0, 0, 4'h2);
    check("basic miss 2", int'(remap_hit),   0);

    // Relearn from DONE clears everything; old repair no longer hits.
    cyc(1, 0, 4'h0, 0, 4'h5);
    check("relearn spares", int'(spares_used), 0);
    check("relearn ok",     int'(repair_ok),   0);
    check("relearn hit",    int'(remap_hit),   0);
    cyc(0, 0, 4'h0, 0, 4'h5);
    check("relearn hit 5",  int'(remap_hit),   0);

    // Duplicates allocate once.
    cyc(0, 1, 4'h7, 0, 4'h0);
    cyc(0, 1, 4'h7, 0, 4'h0);
    cyc(0, 1, 4'h7, 0, 4'h0);
    check("dup spares", int'(spares_used),  1);
    check("dup unrep",  int'(unrepairable), 0);
`ifdef MBISR_FAIL_COUNT_EN
    check("dup fail_cnt", int'(fail_cnt), 3);
`else
    check("dup fail_cnt", int'(fail_cnt), 0);
`endif
    cyc(0, 0, 4'h0, 1, 4'h0);

    // Overflow: third distinct fail with two spares.
    cyc(1, 0, 4'h0, 0, 4'h0);
    cyc(0, 1, 4'h1, 0, 4'h0);
    cyc(0, 1, 4'h2, 0, 4'h0);
    check("ovf unrep before", int'(unrepairable), 0);
    cyc(0, 1, 4'h3, 0, 4'h0);
    check("ovf unrep",  int'(unrepairable), 1);
    check("ovf spares", int'(spares_used),  2);
    cyc(0, 0, 4'h0, 1, 4'h0);
    check("ovf ok", int'(repair_ok), 0);
    cyc(0, 0, 4'h0, 0, 4'h2);
    check("ovf hit 2", int'(remap_hit), 1);
    check("ovf idx 2", int'(remap_idx), 1);
    cyc(0, 0, 4'h0, 0, 4'h3);
    check("ovf miss 3", int'(remap_hit), 0);

    // Fail and learn_done on the same edge.
    cyc(1, 0, 4'h0, 0, 4'h0);
    cyc(0, 1, 4'hC, 1, 4'h0);
    check("same fail_ready", int'(fail_ready),  0);
    check("same spares",     int'(spares_used), 1);
    check("same ok",         int'(repair_ok),   1);
    cyc(0, 0, 4'h0, 0, 4'hC);
    check("same hit C", int'(remap_hit), 1);
    check("same idx C", int'(remap_idx), 0);

    // learn_start wins over a same-edge fail; fails in DONE are ignored.
    cyc(1, 0, 4'h0, 0, 4'h0);
    cyc(0, 1, 4'h4, 0, 4'h0);
    cyc(1, 1, 4'h9, 0, 4'h0);
    check("restart drop", int'(spares_used), 0);
    cyc(0, 1, 4'h6, 0, 4'h0);
    cyc(0, 0, 4'h0, 1, 4'h0);
    cyc(0, 1, 4'hE, 0, 4'hE);
    check("done ignore spares", int'(spares_used), 1);
    check("done hit 6 miss E",  int'(remap_hit),   0);
    cyc(0, 0, 4'h0, 0, 4'h6);
    check("done hit 6", int'(remap_hit), 1);

    // Asynchronous reset mid-DONE.
    #2 rst_n = 1'b0;
    #1;
    check("arst spares", int'(spares_used),  0);
    check("arst hit",    int'(remap_hit),    0);
    check("arst ok",     int'(repair_ok),    0);
    check("arst unrep",  int'(unrepairable), 0);
    check("arst ready",  int'(fail_ready),   0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc(0, 0, 4'h0, 0, 4'h6);
    check("post-rst hit", int'(remap_hit), 0);
    repeat (2) cyc(0, 0, 4'h0, 0, 4'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
